// File: rtl/coeff_serializer.sv
// coeff_serializer: serializes one captured 4x4 zigzag block of quantized levels into beats
//   clk, rst_n (async, active-low)
//   start/first/levels -> block input, accepted while in_ready
//   o_valid/o_ready    -> beat handshake, o_idx/o_level/o_run/o_last/o_empty beat fields
//   done               -> one-cycle pulse after the last beat transfers
//   COEFF_SERIALIZER_SKIP_ZERO_EN: emit only nonzero levels and report skipped-zero runs
module coeff_serializer #(
  parameter int LW = 16,
  parameter int NC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             first,
  input  logic [LW*NC-1:0] levels,
  output logic             in_ready,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [3:0]       o_idx,
  output logic [LW-1:0]    o_level,
  output logic [3:0]       o_run,
  output logic             o_last,
  output logic             o_empty,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;
  state_t state, state_nx;
  logic [LW-1:0] lev_q [NC];
  logic first_q, empty_q, any_nz, xfer;
  logic [3:0] first_ext, last_q, cur, hi_nz;
  assign first_ext = {3'b000, first_q};
  assign xfer = o_valid & o_ready;
`ifdef COEFF_SERIALIZER_SKIP_ZERO_EN
  logic [3:0] run_q, lo_nz, nxt_nz;
  // lo_nz: first emitted index; nxt_nz: next nonzero past cur, always <= last while cur < last
  always_comb begin
    lo_nz = first_ext;
    nxt_nz = last_q;
    for (int k = NC-1; k >= 0; k--) begin
      lo_nz = (4'(k) >= first_ext && lev_q[k] != '0) ? 4'(k) : lo_nz;
      nxt_nz = (4'(k) > cur && lev_q[k] != '0) ? 4'(k) : nxt_nz;
    end
  end
`endif
  // hi_nz defaults to first so an empty block ends on its single beat at first
  always_comb begin
    hi_nz = first_ext;
    any_nz = 1'b0;
    for (int k = 0; k < NC; k++) begin
      hi_nz = (4'(k) >= first_ext && lev_q[k] != '0) ? 4'(k) : hi_nz;
      any_nz = any_nz | (4'(k) >= first_ext && lev_q[k] != '0);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? SCAN : IDLE;
      SCAN: state_nx = EMIT;
      EMIT: state_nx = (xfer && o_last) ? IDLE : EMIT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    o_valid = state == EMIT;
    o_idx = o_valid ? cur : 4'd0;
    o_level = o_valid ? lev_q[cur] : '0;
`ifdef COEFF_SERIALIZER_SKIP_ZERO_EN
    o_run = o_valid ? run_q : 4'd0;
`else
    o_run = 4'd0;
`endif
    o_last = o_valid & (cur == last_q);
    o_empty = o_valid & empty_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < NC; k++) lev_q[k] <= '0;
      first_q <= 1'b0;
      empty_q <= 1'b0;
      last_q <= 4'd0;
      cur <= 4'd0;
      done <= 1'b0;
`ifdef COEFF_SERIALIZER_SKIP_ZERO_EN
      run_q <= 4'd0;
`endif
    end else begin
      done <= xfer & o_last;
      if (in_ready && start) begin
        for (int k = 0; k < NC; k++) lev_q[k] <= levels[LW*k +: LW];
        first_q <= first;
      end
      if (state == SCAN) begin
        last_q <= hi_nz;
        empty_q <= ~any_nz;
`ifdef COEFF_SERIALIZER_SKIP_ZERO_EN
        cur <= lo_nz;
        run_q <= lo_nz - first_ext;
`else
        cur <= first_ext;
`endif
      end else if (xfer && !o_last) begin
`ifdef COEFF_SERIALIZER_SKIP_ZERO_EN
        cur <= nxt_nz;
        run_q <= nxt_nz - cur - 4'd1;
`else
        cur <= cur + 4'd1;
`endif
      end
    end
endmodule

// File: tb/tb_coeff_serializer.sv
// tb_coeff_serializer: scoreboard bench for coeff_serializer
module tb_coeff_serializer;
  localparam int LW = 16;
  localparam int NC = 16;
  logic clk = 0, rst_n = 0, start = 0, first = 0, o_ready = 0;
  logic [LW*NC-1:0] levels = '0;
  logic in_ready, o_valid, o_last, o_empty, done;
  logic [3:0] o_idx, o_run;
  logic [LW-1:0] o_level;
  int checks = 0, errors = 0;
  typedef struct {int idx; logic [LW-1:0] lvl; int run; bit last; bit empty;} beat_t;
  beat_t exp_q[$];
  coeff_serializer #(.LW(LW), .NC(NC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first(first), .levels(levels),
    .in_ready(in_ready), .o_valid(o_valid), .o_ready(o_ready), .o_idx(o_idx),
    .o_level(o_level), .o_run(o_run), .o_last(o_last), .o_empty(o_empty), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, want);
    end
  endtask
  function automatic logic [LW-1:0] lv_at(input logic [LW*NC-1:0] lv, input int k);
    return lv[LW*k +: LW];
  endfunction
  task automatic model(input logic [LW*NC-1:0] lv, input logic f);
    int hi, z;
    hi = -1;
    z = 0;
    for (int k = int'(f); k < NC; k++) if (lv_at(lv, k) != 0) hi = k;
    if (hi < 0) exp_q.push_back('{int'(f), '0, 0, 1'b1, 1'b1});
    else
      for (int k = int'(f); k <= hi; k++) begin
`ifdef COEFF_SERIALIZER_SKIP_ZERO_EN
        if (lv_at(lv, k) == 0) z++;
        else begin
          exp_q.push_back('{k, lv_at(lv, k), z, k == hi, 1'b0});
          z = 0;
        end
`else
        exp_q.push_back('{k, lv_at(lv, k), 0, k == hi, 1'b0});
`endif
      end
  endtask
  // mode 0: ready high, 1: ready 1010..., 2: random ready; inject: pulse start mid-block
  task automatic send(input logic [LW*NC-1:0] lv, input logic f, input int mode, input bit inject);
    int cyc, w;
    bit fin, pend;
    logic [3:0] s_idx, s_run;
    logic [LW-1:0] s_lvl;
    logic s_last, s_empty;
    beat_t e;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk("idle_wait", {31'd0, in_ready}, 1);
    model(lv, f);
    levels = lv;
    first = f;
    start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    chk("lat_scan_valid", {31'd0, o_valid}, 0);
    chk("lat_scan_ready", {31'd0, in_ready}, 0);
    cyc = 0;
    fin = 0;
    pend = 0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      if (cyc == 0) chk("lat_emit_valid", {31'd0, o_valid}, 1);
      if (inject && cyc == 1) begin start = 1; levels = ~lv; first = ~f; end
      if (inject && cyc == 2) start = 0;
      o_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (pend) begin
        chk("stall_idx", {28'd0, o_idx}, {28'd0, s_idx});
        chk("stall_level", {16'd0, o_level}, {16'd0, s_lvl});
        chk("stall_run", {28'd0, o_run}, {28'd0, s_run});
        chk("stall_last", {31'd0, o_last}, {31'd0, s_last});
        chk("stall_empty", {31'd0, o_empty}, {31'd0, s_empty});
      end
      if (!o_valid) begin
        chk("valid_held", {31'd0, o_valid}, 1);
        fin = 1;
      end else if (o_ready) begin
        pend = 0;
        if (exp_q.size() == 0) begin
          chk("extra_beat", {28'd0, o_idx}, 32'hffff_ffff);
          fin = 1;
        end else begin
          e = exp_q.pop_front();
          chk("idx", {28'd0, o_idx}, e.idx);
          chk("level", {16'd0, o_level}, {16'd0, e.lvl});
          chk("run", {28'd0, o_run}, e.run);
          chk("last", {31'd0, o_last}, {31'd0, e.last});
          chk("empty", {31'd0, o_empty}, {31'd0, e.empty});
          fin = e.last;
        end
      end else begin
        pend = 1;
        s_idx = o_idx; s_lvl = o_level; s_run = o_run; s_last = o_last; s_empty = o_empty;
      end
      cyc++;
    end
    if (!fin) chk("timeout", 0, 1);
    @(negedge clk);
    o_ready = 0;
    chk("done_pulse", {31'd0, done}, 1);
    chk("valid_drop", {31'd0, o_valid}, 0);
    chk("back_idle", {31'd0, in_ready}, 1);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    chk("done_once", {31'd0, done}, 0);
  endtask
  logic [LW*NC-1:0] lv;
  initial begin
    #1;
    chk("rst_valid", {31'd0, o_valid}, 0);
    chk("rst_idx", {28'd0, o_idx}, 0);
    chk("rst_level", {16'd0, o_level}, 0);
    chk("rst_run", {28'd0, o_run}, 0);
    chk("rst_flags", {29'd0, o_last, o_empty, done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    send('0, 0, 0, 0);
    lv = '0; lv[15:0] = 16'd7;
    send(lv, 1, 0, 0);
    lv = '0; lv[15:0] = 16'd3; lv[LW*5 +: LW] = 16'hfffe;
    send(lv, 0, 0, 0);
    lv = '0; lv[LW*15 +: LW] = 16'd1;
    send(lv, 0, 1, 0);
    lv = '0; lv[LW*2 +: LW] = 16'h0010; lv[LW*9 +: LW] = 16'h8000;
    send(lv, 1, 0, 1);
    lv = '0; lv[LW*3 +: LW] = 16'd5;
    send(lv, 0, 0, 0);
    lv = '0;
    for (int k = 0; k < 5; k++) lv[LW*k +: LW] = 16'(k + 1);
    @(negedge clk);
    levels = lv; first = 0; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    o_ready = 1;
    repeat (3) @(negedge clk);
    chk("mid_idx", {28'd0, o_idx}, 2);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", {31'd0, o_valid}, 0);
    chk("mid_rst_idx", {28'd0, o_idx}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, o_valid}, 0);
      chk("post_rst_ready", {31'd0, in_ready}, 1);
    end
    o_ready = 0;
    send(lv, 0, 0, 0);
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < NC; k++) lv[LW*k +: LW] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'd0;
      send(lv, 1'($urandom_range(0, 1)), 2, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
